// File: rtl/lpc_peripheral.sv
// LPC bus target: decodes host I/O and memory read/write cycles on LAD and
// hands them to a local provider through a request/done handshake.
module lpc_peripheral (
    input  logic        clk_i,
    input  logic        LRESET,
    input  logic        lframe_i,
    inout  wire  [3:0]  lad_bus,
    inout  wire  [7:0]  lpc_data_io,
    output logic [15:0] lpc_addr_o,
    output logic        lpc_data_wr,
    input  logic        lpc_wr_done,
    input  logic        lpc_data_rd,
    output logic        lpc_data_req
);

    // The cycle-type nibble is decoded in START on the first clock that
    // LFRAME is high, so there is no separate CYCTYPE state.
    typedef enum logic [3:0] {
        IDLE, START, ADDR, WDATA_L, WDATA_H, HTAR1, HTAR2,
        SYNC, RDATA_L, RDATA_H, PTAR1, PTAR2
    } state_t;

    state_t      state, state_d;
    logic        cyc_wr;
    logic [2:0]  nib_cnt;
    logic [15:0] addr_sh;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic [3:0]  lad_out;
    logic        lad_oe;
    logic        data_oe;
    logic        abort;
    logic        resp;

    assign abort = (state != IDLE) && !lframe_i;
    assign resp  = cyc_wr ? lpc_wr_done : lpc_data_rd;

    // Gating with LFRAME releases LAD in the same cycle the host aborts.
    assign lad_bus     = (lad_oe && lframe_i) ? lad_out : 4'bzzzz;
    assign lpc_data_io = data_oe ? wdata_q : 8'hzz;

    always_ff @(posedge clk_i or negedge LRESET) begin
        if (!LRESET) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        if (abort) begin
            state_d = (lad_bus == 4'b0000) ? START : IDLE;
        end else begin
            case (state)
                IDLE:    if (!lframe_i && lad_bus == 4'b0000) state_d = START;
                // CYCTYPE[3:1] of 000..011 are the only supported cycles
                START:   state_d = lad_bus[3] ? IDLE : ADDR;
                ADDR:    if (nib_cnt == 3'd0) state_d = cyc_wr ? WDATA_L : HTAR1;
                WDATA_L: state_d = WDATA_H;
                WDATA_H: state_d = HTAR1;
                HTAR1:   state_d = HTAR2;
                HTAR2:   state_d = SYNC;
                SYNC:    if (resp) state_d = cyc_wr ? PTAR1 : RDATA_L;
                RDATA_L: state_d = RDATA_H;
                RDATA_H: state_d = PTAR1;
                PTAR1:   state_d = PTAR2;
                PTAR2:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge LRESET) begin
        if (!LRESET) begin
            cyc_wr       <= 1'b0;
            nib_cnt      <= 3'd0;
            addr_sh      <= 16'h0000;
            wdata_q      <= 8'h00;
            rdata_q      <= 8'h00;
            lad_out      <= 4'b0000;
            lad_oe       <= 1'b0;
            data_oe      <= 1'b0;
            lpc_addr_o   <= 16'h0000;
            lpc_data_wr  <= 1'b0;
            lpc_data_req <= 1'b0;
        end else if (abort) begin
            lad_oe       <= 1'b0;
            data_oe      <= 1'b0;
            lpc_data_wr  <= 1'b0;
            lpc_data_req <= 1'b0;
        end else begin
            case (state)
                START: begin
                    cyc_wr  <= lad_bus[1];
                    nib_cnt <= lad_bus[2] ? 3'd7 : 3'd3;
                end
                // Shifting through 16 bits leaves only the low half of a memory address
                ADDR: begin
                    addr_sh <= {addr_sh[11:0], lad_bus};
                    nib_cnt <= nib_cnt - 3'd1;
                    if (nib_cnt == 3'd0) lpc_addr_o <= {addr_sh[11:0], lad_bus};
                end
                WDATA_L: wdata_q[3:0] <= lad_bus;
                WDATA_H: wdata_q[7:4] <= lad_bus;
                HTAR2: begin
                    lad_oe  <= 1'b1;
                    lad_out <= 4'b0110;
                    if (cyc_wr) begin
                        lpc_data_wr <= 1'b1;
                        data_oe     <= 1'b1;
                    end else begin
                        lpc_data_req <= 1'b1;
                    end
                end
                SYNC: if (resp) begin
                    lad_out     <= 4'b0000;
                    lpc_data_wr <= 1'b0;
                    data_oe     <= 1'b0;
                    if (!cyc_wr) rdata_q <= lpc_data_io;
                end
                RDATA_L: begin
                    lpc_data_req <= 1'b0;
                    lad_out      <= rdata_q[3:0];
                end
                RDATA_H: lad_out <= rdata_q[7:4];
                PTAR1:   lad_out <= 4'b1111;
                PTAR2:   lad_oe  <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_peripheral.sv
// Bench for lpc_peripheral: directed LPC host cycles, a provider model and a
// per-cycle compare of the LAD trace against the expected protocol sequence.
module tb_lpc_peripheral;

    logic        clk_i = 1'b0;
    logic        LRESET = 1'b0;
    logic        lframe_i = 1'b1;
    logic [3:0]  host_lad = 4'hF;
    logic        host_oe = 1'b0;
    wire  [3:0]  lad_bus;
    wire  [7:0]  lpc_data_io;
    logic [15:0] lpc_addr_o;
    logic        lpc_data_wr;
    logic        lpc_wr_done = 1'b0;
    logic        lpc_data_rd = 1'b0;
    logic        lpc_data_req;

    logic        prov_oe = 1'b0;
    logic [7:0]  prov_rdata = 8'h00;
    int          prov_delay = 0;
    int          wait_cnt = 0;
    logic [7:0]  got_wdata = 8'h00;
    logic [15:0] got_addr = 16'h0000;
    int          wr_pulses = 0;
    int          req_pulses = 0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          lw_seen = 0;
    // entry: {expect_z, check_data, data[7:0], wr, req, lad[3:0]}
    logic [15:0] exp_q[$];

    assign lad_bus     = host_oe ? host_lad : 4'bzzzz;
    assign lpc_data_io = prov_oe ? prov_rdata : 8'hzz;

    lpc_peripheral dut (
        .clk_i        (clk_i),
        .LRESET       (LRESET),
        .lframe_i     (lframe_i),
        .lad_bus      (lad_bus),
        .lpc_data_io  (lpc_data_io),
        .lpc_addr_o   (lpc_addr_o),
        .lpc_data_wr  (lpc_data_wr),
        .lpc_wr_done  (lpc_wr_done),
        .lpc_data_rd  (lpc_data_rd),
        .lpc_data_req (lpc_data_req)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic chk_z(input string name, input logic ok, input logic [31:0] act);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: bus driven with %h, expected Z (t=%0t)", name, act, $time);
        end
    endtask

    function automatic logic [15:0] mk(input logic z, input logic cd, input logic [7:0] d,
                                       input logic wr, input logic rq, input logic [3:0] l);
        return {z, cd, d, wr, rq, l};
    endfunction

    // ---------------- provider model ----------------
    always @(posedge clk_i) begin
        #1;
        if (!LRESET) begin
            lpc_wr_done = 1'b0;
            lpc_data_rd = 1'b0;
            prov_oe     = 1'b0;
            wait_cnt    = 0;
        end else begin
            if (lpc_data_wr && !lpc_wr_done) begin
                if (wait_cnt >= prov_delay) begin
                    lpc_wr_done = 1'b1;
                    got_wdata   = lpc_data_io;
                    got_addr    = lpc_addr_o;
                    wr_pulses++;
                    wait_cnt    = 0;
                end else begin
                    wait_cnt++;
                end
            end else if (!lpc_data_wr) begin
                lpc_wr_done = 1'b0;
            end
            if (lpc_data_req && !lpc_data_rd) begin
                if (wait_cnt >= prov_delay) begin
                    lpc_data_rd = 1'b1;
                    prov_oe     = 1'b1;
                    got_addr    = lpc_addr_o;
                    req_pulses++;
                    wait_cnt    = 0;
                end else begin
                    wait_cnt++;
                end
            end else if (!lpc_data_req) begin
                lpc_data_rd = 1'b0;
                prov_oe     = 1'b0;
            end
            if (!lpc_data_wr && !lpc_data_req) wait_cnt = 0;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk_i) begin
        logic [15:0] e;
        chk("wr_req_exclusive", 32'(lpc_data_wr & lpc_data_req), 32'd0);
        if (!lpc_data_wr && !prov_oe)
            chk_z("data_io_released", lpc_data_io === 8'hzz, 32'(lpc_data_io));
        if (exp_q.size() > 0 && cyc >= start_cyc) begin
            e = exp_q.pop_front();
            if (lad_bus === 4'b0110) lw_seen++;
            if (e[15]) chk_z("lad_release", lad_bus === 4'bzzzz, 32'(lad_bus));
            else       chk("lad", 32'(lad_bus), 32'(e[3:0]));
            chk("data_wr", 32'(lpc_data_wr), 32'(e[5]));
            chk("data_req", 32'(lpc_data_req), 32'(e[4]));
            if (e[14]) chk("wdata_io", 32'(lpc_data_io), 32'(e[13:6]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic fr, input logic [3:0] v);
        @(negedge clk_i);
        lframe_i = fr;
        host_lad = v;
        host_oe  = 1'b1;
    endtask

    task automatic host_idle();
        host_oe  = 1'b1;
        host_lad = 4'hF;
        lframe_i = 1'b1;
    endtask

    task automatic host_phase(input logic is_mem, input logic is_wr,
                              input logic [31:0] addr, input logic [7:0] data);
        drive(1'b0, 4'h0);
        drive(1'b1, {1'b0, is_mem, is_wr, 1'b0});
        for (int i = (is_mem ? 7 : 3); i >= 0; i--) drive(1'b1, addr[i*4 +: 4]);
        if (is_wr) begin
            drive(1'b1, data[3:0]);
            drive(1'b1, data[7:4]);
        end
        drive(1'b1, 4'hF);
        @(negedge clk_i);
        host_oe = 1'b0;
    endtask

    // Expected trace: long-wait SYNC for every clock the provider has not yet
    // answered (delay+1), ready SYNC, read nibbles low first, 1111, then Z.
    task automatic run_cycle(input logic is_mem, input logic is_wr, input logic [31:0] addr,
                             input logic [7:0] data, input int delay);
        prov_delay = delay;
        prov_rdata = data;
        lw_seen    = 0;
        host_phase(is_mem, is_wr, addr, data);
        for (int i = 0; i <= delay; i++)
            exp_q.push_back(mk(1'b0, is_wr, data, is_wr, !is_wr, 4'b0110));
        exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, !is_wr, 4'b0000));
        if (!is_wr) begin
            exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, data[3:0]));
            exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, data[7:4]));
        end
        exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b1111));
        exp_q.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000));
        start_cyc = cyc + 1;
        for (int k = 0; k < 400 && exp_q.size() > 0; k++) begin
            @(negedge clk_i);
            #1;
        end
        chk("trace_complete", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        chk("addr_o", 32'(lpc_addr_o), 32'(addr[15:0]));
        chk("provider_addr", 32'(got_addr), 32'(addr[15:0]));
        if (is_wr) chk("provider_wdata", 32'(got_wdata), 32'(data));
        host_idle();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int wp, rp;
        logic [31:0] a;

        @(negedge clk_i);
        chk("reset_addr", 32'(lpc_addr_o), 32'd0);
        chk("reset_wr", 32'(lpc_data_wr), 32'd0);
        chk("reset_req", 32'(lpc_data_req), 32'd0);
        chk_z("reset_lad", lad_bus === 4'bzzzz, 32'(lad_bus));
        chk_z("reset_data_io", lpc_data_io === 8'hzz, 32'(lpc_data_io));
        LRESET = 1'b1;
        host_idle();
        repeat (2) @(negedge clk_i);

        // I/O write, provider answers at once
        run_cycle(1'b0, 1'b1, 32'h0000_F0F0, 8'h5A, 0);
        chk("t1_long_waits", 32'(lw_seen), 32'd1);
        chk("t1_wdata_lit", 32'(got_wdata), 32'h5A);
        chk("t1_addr_lit", 32'(lpc_addr_o), 32'hF0F0);

        // I/O write, provider waits 10 clocks
        run_cycle(1'b0, 1'b1, 32'h0000_9696, 8'hA5, 10);
        chk("t2_long_waits", 32'(lw_seen), 32'd11);

        // I/O read returning 0xA5 after 10 clocks
        run_cycle(1'b0, 1'b0, 32'h0000_1234, 8'hA5, 10);
        chk("t3_long_waits", 32'(lw_seen), 32'd11);
        chk("t3_addr_lit", 32'(lpc_addr_o), 32'h1234);

        // Alternating I/O and memory; upper memory address bits are discarded
        for (int i = 0; i <= 8; i++) begin
            a = {16'hFEDC, 8'h00, 8'(i)};
            run_cycle(i % 2 == 1, 1'b1, a, 8'(i), i % 3);
            run_cycle(i % 2 == 1, 1'b0, a, 8'hBB + 8'(i), i % 4);
        end
        chk("loop_addr_lit", 32'(lpc_addr_o), 32'h0008);

        // Unsupported cycle type: target must stay off the bus
        wp = wr_pulses; rp = req_pulses;
        drive(1'b0, 4'h0);
        drive(1'b1, 4'h8);
        repeat (3) drive(1'b1, 4'h1);
        @(negedge clk_i);
        host_oe = 1'b0;
        repeat (4) begin
            @(negedge clk_i);
            #1;
            chk_z("bad_cyctype_lad", lad_bus === 4'bzzzz, 32'(lad_bus));
        end
        chk("bad_cyctype_wr", 32'(wr_pulses - wp), 32'd0);
        chk("bad_cyctype_req", 32'(req_pulses - rp), 32'd0);
        host_idle();

        // Reset between cycles
        host_oe = 1'b0;
        @(negedge clk_i);
        #2 LRESET = 1'b0;
        #1;
        chk("rst_idle_addr", 32'(lpc_addr_o), 32'd0);
        chk_z("rst_idle_lad", lad_bus === 4'bzzzz, 32'(lad_bus));
        @(negedge clk_i);
        LRESET = 1'b1;
        host_idle();

        // Reset during long-wait SYNC of a write
        prov_delay = 500;
        host_phase(1'b0, 1'b1, 32'h0000_1234, 8'h77);
        repeat (3) @(negedge clk_i);
        #1;
        chk("sync_wr_held", 32'(lpc_data_wr), 32'd1);
        chk("sync_lad_wait", 32'(lad_bus), 32'h6);
        chk("sync_data_io", 32'(lpc_data_io), 32'h77);
        #2 LRESET = 1'b0;
        #1;
        chk("rst_sync_wr", 32'(lpc_data_wr), 32'd0);
        chk("rst_sync_req", 32'(lpc_data_req), 32'd0);
        chk("rst_sync_addr", 32'(lpc_addr_o), 32'd0);
        chk_z("rst_sync_lad", lad_bus === 4'bzzzz, 32'(lad_bus));
        chk_z("rst_sync_data_io", lpc_data_io === 8'hzz, 32'(lpc_data_io));
        @(negedge clk_i);
        host_idle();
        @(negedge clk_i);
        LRESET = 1'b1;
        run_cycle(1'b1, 1'b1, 32'hCAFE_0042, 8'h42, 1);

        // Abort mid-address with LAD=0000 restarts a new cycle directly
        wp = wr_pulses; rp = req_pulses;
        drive(1'b0, 4'h0);
        drive(1'b1, 4'h2);
        drive(1'b1, 4'hA);
        drive(1'b1, 4'hB);
        run_cycle(1'b0, 1'b0, 32'h0000_1357, 8'h3C, 2);
        chk("abort_wr_pulses", 32'(wr_pulses - wp), 32'd0);
        chk("abort_req_pulses", 32'(req_pulses - rp), 32'd1);

        // Abort with non-zero LAD returns to idle
        wp = wr_pulses;
        drive(1'b0, 4'h0);
        drive(1'b1, 4'h6);
        drive(1'b1, 4'h1);
        drive(1'b0, 4'h5);
        drive(1'b1, 4'hF);
        run_cycle(1'b1, 1'b1, 32'h0000_BEEF, 8'h99, 0);
        chk("abort2_wr_pulses", 32'(wr_pulses - wp), 32'd1);
        chk("abort2_addr_lit", 32'(lpc_addr_o), 32'hBEEF);

        repeat (3) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
